// File: rtl/output_port_arbiter_if.sv
// Bundles the per-input request/status lines and the port-owner outputs of one
// router output-port arbiter.
interface output_port_arbiter_if;
  logic [4:0] req;
  logic [4:0] empty;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] grant;
  logic [4:0] rd_en;
  logic       valid_out;
  logic [2:0] credit_cnt;
  logic       busy;

  modport master (
    output req, empty, tail, credit_in,
    input  grant, rd_en, valid_out, credit_cnt, busy
  );

  modport slave (
    input  req, empty, tail, credit_in,
    output grant, rd_en, valid_out, credit_cnt, busy
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin, packet-locked owner selection for one output port, with
// credit-based flow control toward the downstream input buffer.
module output_port_arbiter #(
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_dbg_state,
  output_port_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [2:0] C_MAX = 3'(CREDITS);

  state_t     r_state;
  logic [4:0] r_grant;
  logic [2:0] r_ptr;
  logic [2:0] r_credit;

  logic       w_found;
  logic [2:0] w_sel_idx;
  logic [4:0] w_sel_onehot;
  logic [4:0] w_rd_en;
  logic       w_valid;
  logic       w_tail_xfer;

  // Search starts one past the last winner so the previous owner goes last.
  always_comb begin
    logic [3:0] v_sum;
    w_found   = 1'b0;
    w_sel_idx = 3'd0;
    v_sum     = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      v_sum = {1'b0, r_ptr} + 4'(k);
      if (v_sum >= 4'd5) v_sum = v_sum - 4'd5;
      if (!w_found && bus.req[v_sum[2:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = v_sum[2:0];
      end
    end
    w_sel_onehot = 5'b00001 << w_sel_idx;
  end

  // A flit crosses (rd_en pops the owner FIFO, valid_out marks it on the port)
  // exactly when the owner has data and a downstream slot is available.
  always_comb begin
    w_rd_en = 5'b00000;
    if (!rst && r_state == ACTIVE && r_credit != 3'd0)
      w_rd_en = r_grant & ~bus.empty;
    w_valid     = |w_rd_en;
    w_tail_xfer = |(w_rd_en & bus.tail);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= 5'b00000;
      r_ptr    <= 3'd4;
      r_credit <= C_MAX;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= ACTIVE;
            r_grant <= w_sel_onehot;
            r_ptr   <= w_sel_idx;
          end
        end
        ACTIVE: begin
          if (w_tail_xfer) begin
            r_state <= IDLE;
            r_grant <= 5'b00000;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 5'b00000;
        end
      endcase

      // Simultaneous send and return cancel; returns beyond capacity are dropped.
      case ({w_valid, bus.credit_in})
        2'b10: r_credit <= r_credit - 3'd1;
        2'b01: if (r_credit < C_MAX) r_credit <= r_credit + 3'd1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.rd_en      = w_rd_en;
  assign bus.valid_out  = w_valid;
  assign bus.credit_cnt = r_credit;
  assign bus.busy       = (r_state == ACTIVE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: arbitration order, packet locking,
// credit accounting and reset behaviour against hand-computed values.
module tb_output_port_arbiter;

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_vec;
  int   n_err;

  output_port_arbiter_if bus ();

  output_port_arbiter #(.CREDITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .o_dbg_state (dbg_state),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [4:0] exp_order [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.req = 5'b0; bus.empty = 5'b0; bus.tail = 5'b0; bus.credit_in = 1'b0;
    rst = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_grant", 8'(bus.grant), 8'h00);
    check("rst_busy", 8'(bus.busy), 8'h00);
    check("rst_credit", 8'(bus.credit_cnt), 8'd4);
    check("rst_rd_en", 8'(bus.rd_en), 8'h00);
    check("rst_dbg_state", 8'(dbg_state), 8'h00);
    rst = 1'b0;

    // N and L request: N first after reset, L next after N's tail
    bus.req = 5'b10001;
    #1;
    check("idle_rd_en", 8'(bus.rd_en), 8'h00);
    check("idle_valid", 8'(bus.valid_out), 8'h00);
    tick();
    check("nl_grant_n", 8'(bus.grant), 8'h01);
    check("nl_busy", 8'(bus.busy), 8'h01);
    bus.tail = 5'b00001;
    #1;
    check("nl_rd_en_n", 8'(bus.rd_en), 8'h01);
    check("nl_valid_n", 8'(bus.valid_out), 8'h01);
    tick();
    check("nl_tail_grant", 8'(bus.grant), 8'h00);
    check("nl_tail_busy", 8'(bus.busy), 8'h00);
    check("nl_credit3", 8'(bus.credit_cnt), 8'd3);
    bus.tail = 5'b10000;
    tick();
    check("nl_grant_l", 8'(bus.grant), 8'h10);
    check("nl_rd_en_l", 8'(bus.rd_en), 8'h10);
    tick();
    check("nl_l_done", 8'(bus.grant), 8'h00);
    check("nl_credit2", 8'(bus.credit_cnt), 8'd2);
    bus.req = 5'b0; bus.tail = 5'b0;
    bus.credit_in = 1'b1;
    tick(); tick();
    bus.credit_in = 1'b0;
    check("idle_credit_return", 8'(bus.credit_cnt), 8'd4);

    // All requesting, 2-flit packets, credit returned on every transfer
    do_reset();
    exp_order[0] = 5'b00001; exp_order[1] = 5'b00010; exp_order[2] = 5'b00100;
    exp_order[3] = 5'b01000; exp_order[4] = 5'b10000; exp_order[5] = 5'b00001;
    bus.req = 5'b11111; bus.empty = 5'b0; bus.credit_in = 1'b1;
    for (int p = 0; p < 6; p++) begin
      tick();
      check($sformatf("rr_grant_%0d", p), 8'(bus.grant), 8'(exp_order[p]));
      bus.tail = 5'b0;
      #1;
      check($sformatf("rr_rd_en_%0d", p), 8'(bus.rd_en), 8'(exp_order[p]));
      tick();
      bus.tail = 5'b11111;
      #1;
      check($sformatf("rr_valid_tail_%0d", p), 8'(bus.valid_out), 8'h01);
      tick();
      check($sformatf("rr_release_%0d", p), 8'(bus.grant), 8'h00);
      bus.tail = 5'b0;
    end
    check("rr_credit_held", 8'(bus.credit_cnt), 8'd4);
    bus.req = 5'b0; bus.credit_in = 1'b0;

    // E sends a 6-flit packet with no credit returns
    do_reset();
    bus.req = 5'b00010;
    tick();
    check("cr_grant_e", 8'(bus.grant), 8'h02);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("cr_rd_en_%0d", f), 8'(bus.rd_en), 8'h02);
      tick();
    end
    check("cr_credit0", 8'(bus.credit_cnt), 8'd0);
    check("cr_stall_rd_en", 8'(bus.rd_en), 8'h00);
    check("cr_stall_valid", 8'(bus.valid_out), 8'h00);
    tick();
    check("cr_stall_grant", 8'(bus.grant), 8'h02);
    bus.credit_in = 1'b1;
    #1;
    check("cr_credit_in_rd_en", 8'(bus.rd_en), 8'h00);
    tick();
    bus.credit_in = 1'b0;
    check("cr_credit1", 8'(bus.credit_cnt), 8'd1);
    check("cr_one_xfer", 8'(bus.rd_en), 8'h02);
    tick();
    check("cr_back_to0", 8'(bus.credit_cnt), 8'd0);
    check("cr_stall_again", 8'(bus.rd_en), 8'h00);
    bus.credit_in = 1'b1;
    tick();
    bus.credit_in = 1'b0;
    bus.tail = 5'b00010;
    #1;
    check("cr_tail_rd_en", 8'(bus.rd_en), 8'h02);
    tick();
    check("cr_tail_release", 8'(bus.grant), 8'h00);
    bus.tail = 5'b0; bus.req = 5'b0;
    bus.credit_in = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    bus.credit_in = 1'b0;
    check("cr_saturate", 8'(bus.credit_cnt), 8'd4);

    // W: send and return in the same cycle, then owner stalls and drops req
    bus.req = 5'b00100;
    tick();
    check("w_grant", 8'(bus.grant), 8'h04);
    tick(); tick();
    check("w_credit2", 8'(bus.credit_cnt), 8'd2);
    bus.credit_in = 1'b1;
    #1;
    check("w_valid_with_cin", 8'(bus.valid_out), 8'h01);
    tick();
    check("w_credit_hold2", 8'(bus.credit_cnt), 8'd2);
    bus.credit_in = 1'b0;
    bus.req = 5'b01001; bus.empty = 5'b00100;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("w_stall_rd_en_%0d", s), 8'(bus.rd_en), 8'h00);
      tick();
      check($sformatf("w_stall_grant_%0d", s), 8'(bus.grant), 8'h04);
    end
    check("w_stall_busy", 8'(bus.busy), 8'h01);
    bus.empty = 5'b0; bus.tail = 5'b00100;
    #1;
    check("w_tail_rd_en", 8'(bus.rd_en), 8'h04);
    tick();
    check("w_release", 8'(bus.grant), 8'h00);
    check("w_credit1", 8'(bus.credit_cnt), 8'd1);

    // S owns the port with one credit left when reset hits mid-packet
    bus.tail = 5'b0; bus.req = 5'b01000;
    tick();
    check("s_grant", 8'(bus.grant), 8'h08);
    rst = 1'b1; bus.credit_in = 1'b1; bus.tail = 5'b01000;
    #1;
    check("s_rst_rd_en", 8'(bus.rd_en), 8'h00);
    check("s_rst_valid", 8'(bus.valid_out), 8'h00);
    tick();
    rst = 1'b0; bus.credit_in = 1'b0; bus.tail = 5'b0; bus.req = 5'b0;
    #1;
    check("s_rst_grant", 8'(bus.grant), 8'h00);
    check("s_rst_busy", 8'(bus.busy), 8'h00);
    check("s_rst_credit", 8'(bus.credit_cnt), 8'd4);
    check("s_post_rd_en", 8'(bus.rd_en), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter: CREDITS, 4, downstream input-buffer depth in flits (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  5  per-input request for this output port (bit0 N, bit1 E, bit2 W, bit3 S, bit4 L), driven by each input's LBDR port bit.
REQ-005 empty  input  5  per-input FIFO empty flag, same bit order.
REQ-006 tail  input  5  per-input flag: flit at FIFO head is `TAIL (from shared parameters include).
REQ-007 credit_in  input  1  one downstream buffer slot freed this cycle.
REQ-008 grant  output  5  registered one-hot owner of the output port; 0 when unowned.
REQ-009 rd_en  output  5  combinational pop strobe to input FIFO i.
REQ-010 valid_out  output  1  combinational; a flit crosses the output port this cycle.
REQ-011 credit_cnt  output  3  registered available downstream credits.
REQ-012 busy  output  1  registered; high in ACTIVE state.

Function
REQ-013 The block SHALL implement two states: IDLE and ACTIVE.
REQ-014 In IDLE, grant SHALL be 0, rd_en 0, valid_out 0.
REQ-015 In IDLE with req != 0, the block SHALL select the first requesting index searching (ptr+1) mod 5 upward with wrap, load grant one-hot, set ptr to that index, and enter ACTIVE on the next edge (grant visible 1 cycle after req sampled).
REQ-016 req SHALL be sampled only in IDLE; in ACTIVE req changes, including deassertion by the owner, SHALL NOT affect grant.
REQ-017 In ACTIVE, rd_en[i] SHALL equal grant[i] & ~empty[i] & (credit_cnt != 0); valid_out SHALL equal OR of rd_en.
REQ-018 When rd_en[i] & tail[i] in ACTIVE, the block SHALL return to IDLE on the next edge with grant cleared; no new grant in that same edge.
REQ-019 A new arbitration SHALL therefore start no earlier than the first IDLE cycle after a tail (tail at cycle t, IDLE at t+1, new grant at t+2).
REQ-020 credit_cnt SHALL decrement by 1 on valid_out, increment by 1 on credit_in, and stay unchanged when both occur in the same cycle.
REQ-021 credit_cnt SHALL saturate at CREDITS: credit_in with credit_cnt == CREDITS and no valid_out SHALL be ignored.
REQ-022 credit_cnt SHALL never underflow; gating in REQ-017 guarantees no transfer at 0.
REQ-023 credit_in SHALL be honoured in both IDLE and ACTIVE.
REQ-024 A stalled owner (empty or zero credits) SHALL keep grant indefinitely; no timeout.
REQ-025 Round-robin fairness: an input requesting continuously SHALL be granted within 5 arbitration rounds.

Reset
REQ-026 On rst high at a posedge: state IDLE, grant 0, busy 0, ptr 4 (first priority to N), credit_cnt CREDITS.
REQ-027 rst mid-packet SHALL abandon the packet immediately; rd_en and valid_out SHALL be 0 in every cycle rst is high.
REQ-028 rst SHALL take priority over credit_in, tail and req in the same cycle.

Verification
REQ-029 After reset, req=5'b10001 -> next cycle grant=5'b00001, busy=1; after N tail, next grant=5'b10000 (L).
REQ-030 All req=5'b11111 held, 2-flit packets, empty=0, credit_in each transfer -> grant order N,E,W,S,L,N.
REQ-031 CREDITS=4, no credit_in, 6-flit packet from E -> 4 transfers, credit_cnt=0, rd_en=0 stall; one credit_in -> one transfer, credit_cnt returns to 0.
REQ-032 valid_out and credit_in same cycle at credit_cnt=2 -> credit_cnt stays 2; credit_in at credit_cnt=4 idle -> stays 4.
REQ-033 Owner W drops req and empty=1 mid-packet -> grant stays 5'b00100 until W tail transferred.
REQ-034 rst asserted during S packet with credit_cnt=1 -> next cycle grant=0, busy=0, credit_cnt=4, rd_en=0.
